// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a single-port data RAM: lane enables, store alignment, load extension, timeout.
// Optional MEM_ALIGN_CHECK_EN adds adel/ades and skips the RAM for misaligned half/word accesses.
module mem_access_ctrl #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_en,
    input  logic          mem_we,
    input  logic [1:0]    size,
    input  logic          ld_unsigned,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          stall,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          bus_err,
    output logic          ram_req,
    output logic          ram_we,
    output logic [3:0]    ram_be,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic          ram_ack,
    input  logic [31:0]   ram_rdata
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic          adel,
    output logic          ades
`endif
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t        state_reg, state_next;
    logic          we_reg;
    logic [1:0]    size_reg;
    logic          uns_reg;
    logic [AW-1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [CW-1:0] cnt_reg;
    logic [31:0]   load_reg;
    logic          err_reg;
    logic          misalign;
    logic          fault;
    logic          is_byte;
    logic          is_half;
    logic [3:0]    be_lane;
    logic [31:0]   wdata_lane;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;

`ifdef MEM_ALIGN_CHECK_EN
    logic adel_reg;
    logic ades_reg;

    // Misalignment is judged on the live inputs so a faulting access never reaches BUS.
    assign misalign = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign fault    = err_reg | adel_reg | ades_reg;
    assign adel     = adel_reg;
    assign ades     = ades_reg;
`else
    assign misalign = 1'b0;
    assign fault    = err_reg;
`endif

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = mem_en;
                if (mem_en)
                    state_next = misalign ? DONE : BUS;
            end
            BUS: begin
                stall = 1'b1;
                if (ram_ack || (cnt_reg == CNT_LAST))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            size_reg  <= 2'b00;
            uns_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
            load_reg  <= '0;
            err_reg   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            adel_reg  <= 1'b0;
            ades_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (mem_en) begin
                        we_reg    <= mem_we;
                        size_reg  <= size;
                        uns_reg   <= ld_unsigned;
                        addr_reg  <= addr;
                        wdata_reg <= wdata;
                        cnt_reg   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                        adel_reg  <= misalign & ~mem_we;
                        ades_reg  <= misalign & mem_we;
`endif
                    end
                end
                BUS: begin
                    if (ram_ack)
                        load_reg <= ram_rdata;
                    else if (cnt_reg == CNT_LAST)
                        err_reg <= 1'b1;
                    else
                        cnt_reg <= cnt_reg + 1'b1;
                end
                DONE: begin
                    err_reg  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    adel_reg <= 1'b0;
                    ades_reg <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    // Size 2'b11 falls through to the word case.
    assign is_byte = (size_reg == 2'b00);
    assign is_half = (size_reg == 2'b01);

    always_comb begin
        if (is_byte)
            be_lane = 4'b0001 << addr_reg[1:0];
        else if (is_half)
            be_lane = addr_reg[1] ? 4'b1100 : 4'b0011;
        else
            be_lane = 4'b1111;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_src;
            always_comb begin
                if (is_byte)
                    lane_src = wdata_reg[7:0];
                else if (is_half)
                    lane_src = wdata_reg[8*(gi%2) +: 8];
                else
                    lane_src = wdata_reg[8*gi +: 8];
            end
            assign wdata_lane[8*gi +: 8] = be_lane[gi] ? lane_src : 8'h00;
        end
    endgenerate

    always_comb begin
        if (is_byte) begin
            shifted  = load_reg >> {addr_reg[1:0], 3'b000};
            load_ext = {{24{~uns_reg & shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            shifted  = load_reg >> {addr_reg[1], 4'b0000};
            load_ext = {{16{~uns_reg & shifted[15]}}, shifted[15:0]};
        end else begin
            shifted  = load_reg;
            load_ext = load_reg;
        end
    end

    assign done      = (state_reg == DONE);
    assign bus_err   = err_reg;
    assign rdata     = (done && !we_reg && !fault) ? load_ext : 32'h0;
    assign ram_req   = (state_reg == BUS);
    assign ram_we    = ram_req & we_reg;
    assign ram_be    = ram_req ? be_lane : 4'b0000;
    assign ram_addr  = ram_req ? {addr_reg[AW-1:2], 2'b00} : '0;
    assign ram_wdata = ram_req ? wdata_lane : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expectations, a negedge monitor checks them.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        ld_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall, done, bus_err, ram_req, ram_we;
    logic [31:0] rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_ack = 1'b0;
    logic [31:0] ram_rdata = 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
    logic        adel, ades;
`endif

    mem_access_ctrl #(.AW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .size(size),
        .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata), .stall(stall),
        .done(done), .rdata(rdata), .bus_err(bus_err), .ram_req(ram_req),
        .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata)
`ifdef MEM_ALIGN_CHECK_EN
        , .adel(adel), .ades(ades)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          stalls;
        int          reqs;
        logic        adel;
        logic        ades;
        int          issue;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    exp_t done_q[$];
    bus_t bus_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int txn = 0;
    int ack_delay = 0;
    logic [31:0] ram_word = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // RAM model: ack after ack_delay BUS cycles, never when ack_delay < 0.
    int bus_cycles = 0;
    always @(negedge clk) begin
        if (ram_req) begin
            if (bus_cycles == ack_delay) begin
                ram_ack = 1'b1;
                ram_rdata = ram_word;
            end else begin
                ram_ack = 1'b0;
                ram_rdata = 32'h0;
            end
            bus_cycles++;
        end else begin
            ram_ack = 1'b0;
            ram_rdata = 32'h0;
            bus_cycles = 0;
        end
    end

    // Monitor: bus fields on the first request cycle, results on the done pulse.
    int stall_seen = 0;
    int req_seen = 0;
    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 0;
            req_seen = 0;
        end else begin
            if (stall) stall_seen++;
            if (ram_req) begin
                req_seen++;
                if (req_seen == 1) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_ram_req", 32'(ram_req), 32'h0);
                    end else begin
                        bus_t b;
                        b = bus_q.pop_front();
                        chk("ram_we", 32'(ram_we), 32'(b.we));
                        chk("ram_be", 32'(ram_be), 32'(b.be));
                        chk("ram_addr", ram_addr, b.addr);
                        chk("ram_wdata", ram_wdata, b.wdata);
                    end
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'h0);
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    txn++;
                    $display("txn %0d: rdata=%h bus_err=%0d lat=%0d stalls=%0d reqs=%0d",
                             txn, rdata, bus_err, cyc - e.issue + 1, stall_seen, req_seen);
                    chk("rdata", rdata, e.rdata);
                    chk("bus_err", 32'(bus_err), 32'(e.err));
                    chk("latency", 32'(cyc - e.issue + 1), 32'(e.lat));
                    chk("stall_cycles", 32'(stall_seen), 32'(e.stalls));
                    chk("req_cycles", 32'(req_seen), 32'(e.reqs));
                    chk("stall_in_done", 32'(stall), 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
                    chk("adel", 32'(adel), 32'(e.adel));
                    chk("ades", 32'(ades), 32'(e.ades));
`endif
                end
                stall_seen = 0;
                req_seen = 0;
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int delay, input logic [31:0] word);
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        mem_we = we;
        size = sz;
        ld_unsigned = uns;
        addr = a;
        wdata = wd;
        ack_delay = delay;
        ram_word = word;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'(seen), 32'h1);
    endtask

    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int delay, input logic [31:0] word,
                          input logic [3:0] be, input logic [31:0] bwd,
                          input logic [31:0] rd, input logic err,
                          input int lat, input int stalls, input int reqs,
                          input logic ad_l, input logic ad_s);
        exp_t e;
        bus_t b;
        drive(we, sz, uns, a, wd, delay, word);
        e.rdata = rd; e.err = err; e.lat = lat; e.stalls = stalls; e.reqs = reqs;
        e.adel = ad_l; e.ades = ad_s; e.issue = cyc;
        done_q.push_back(e);
        if (reqs > 0) begin
            b.we = we; b.be = be; b.addr = {a[31:2], 2'b00}; b.wdata = bwd;
            bus_q.push_back(b);
        end
        wait_done();
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        mem_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ram_req", 32'(ram_req), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_ram_be", 32'(ram_be), 32'h0);
        rst = 1'b0;

        // we sz uns addr wdata delay word | be bus_wdata rdata err lat stalls reqs adel ades
        access(1, 2'b00, 0, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0,
               4'b1000, 32'hAB00_0000, 32'h0, 0, 3, 2, 1, 0, 0);
        access(0, 2'b01, 0, 32'h0000_2002, 32'h0, 0, 32'h8001_1234,
               4'b1100, 32'h0, 32'hFFFF_8001, 0, 3, 2, 1, 0, 0);
        access(0, 2'b01, 1, 32'h0000_2002, 32'h0, 0, 32'h8001_1234,
               4'b1100, 32'h0, 32'h0000_8001, 0, 3, 2, 1, 0, 0);
        access(0, 2'b00, 0, 32'h0000_3001, 32'h0, 3, 32'h1122_3344,
               4'b0010, 32'h0, 32'h0000_0033, 0, 6, 5, 4, 0, 0);
        access(0, 2'b00, 0, 32'h0000_9003, 32'h0, 1, 32'h80FF_0000,
               4'b1000, 32'h0, 32'hFFFF_FF80, 0, 4, 3, 2, 0, 0);
        access(1, 2'b01, 0, 32'h0000_7002, 32'h1234_5678, 0, 32'h0,
               4'b1100, 32'h5678_0000, 32'h0, 0, 3, 2, 1, 0, 0);
        access(0, 2'b11, 0, 32'h0000_A000, 32'h0, 0, 32'h1234_5678,
               4'b1111, 32'h0, 32'h1234_5678, 0, 3, 2, 1, 0, 0);
        access(0, 2'b10, 0, 32'h0000_4000, 32'h0, -1, 32'hFFFF_FFFF,
               4'b1111, 32'h0, 32'h0, 1, 18, 17, 16, 0, 0);
        go_idle();
        @(negedge clk);
        chk("idle_after_timeout", 32'({done, bus_err, stall}), 32'h0);

        // Reset in the middle of BUS: everything drops at once and no done follows.
        begin
            bus_t b;
            drive(0, 2'b00, 0, 32'h0000_5000, 32'h0, -1, 32'h0);
            b.we = 0; b.be = 4'b0001; b.addr = 32'h0000_5000; b.wdata = 32'h0;
            bus_q.push_back(b);
        end
        repeat (3) @(negedge clk);
        chk("pre_rst_ram_req", 32'(ram_req), 32'h1);
        rst = 1'b1;
        mem_en = 1'b0;
        #1;
        chk("midbus_rst_ram_req", 32'(ram_req), 32'h0);
        chk("midbus_rst_stall", 32'(stall), 32'h0);
        chk("midbus_rst_done", 32'(done), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        access(1, 2'b10, 0, 32'h0000_6000, 32'hDEAD_BEEF, 0, 32'h0,
               4'b1111, 32'hDEAD_BEEF, 32'h0, 0, 3, 2, 1, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        access(0, 2'b10, 0, 32'h0000_8002, 32'h0, 0, 32'h0,
               4'b0000, 32'h0, 32'h0, 0, 2, 1, 0, 1, 0);
        access(1, 2'b01, 0, 32'h0000_B001, 32'h0000_0055, 0, 32'h0,
               4'b0000, 32'h0, 32'h0, 0, 2, 1, 0, 0, 1);
        access(0, 2'b01, 1, 32'h0000_B002, 32'h0, 0, 32'hBEEF_0000,
               4'b1100, 32'h0, 32'h0000_BEEF, 0, 3, 2, 1, 0, 0);
`endif
        go_idle();
        repeat (3) @(negedge clk);
        chk("done_q_empty", 32'(done_q.size()), 32'h0);
        chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
